uart_receiving_msg: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 118 +++++++++++
 rtl/uart_receiving_msg.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path: receiver FSM state
//   encoding, the bit-period helper and the idle-timeout length in bit
//   periods (used when UART_RX_TIMEOUT_EN is defined).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Idle line length, in bit periods, after which a partial message is dropped
    localparam int TIMEOUT_BITS = 16;

    // Clock cycles per UART bit (integer division, truncating)
    function automatic int bit_ticks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   Single-byte 8N1 UART receiver: 2-flop synchroniser, start-bit
//   qualification at half a bit period, 8 data samples LSB first and a
//   stop-bit check.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  synchronous active-low reset
//   rx         in  asynchronous serial line, idle high
//   data       out last received byte (valid while byte_valid is high)
//   byte_valid out one-cycle pulse, good stop bit sampled
//   frame_err  out one-cycle pulse, stop bit sampled low
//   idle       out receiver is in IDLE (only with UART_RX_TIMEOUT_EN)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
`ifdef UART_RX_TIMEOUT_EN
   ,output logic       idle
`endif
);

    localparam int BIT_TICKS  = bit_ticks(CLK_FREQ, BAUD_RATE);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CW         = $clog2(BIT_TICKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);

    logic [1:0]    sync_q;
    logic          rxs;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;

    assign rxs  = sync_q[1];
    assign data = sh_q;
`ifdef UART_RX_TIMEOUT_EN
    assign idle = (state_q == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    // Counter restarts from 0 on every state change and after every sample,
    // so it never exceeds BIT_LAST.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        sh_d       = sh_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // still low at mid start bit: real frame, else a glitch
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_valid = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_d    = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_receiving_msg.sv
// uart_receiving_msg
//   Packs msg_size_byte UART bytes into one wide message register and holds
//   it (msg_done) until ack. Optional macro UART_RX_TIMEOUT_EN adds an idle
//   timeout that drops a partial message and raises sticky `timeout`.
// Ports:
//   clk           in  system clock, rising edge
//   reset         in  synchronous active-low reset
//   rx            in  asynchronous serial line, idle high
//   ack           in  one-cycle pulse: clear message/status, re-arm
//   msg           out received message, first byte at msg[7:0]
//   msg_done      out high while a complete message is held
//   byte_count    out bytes stored in the current message
//   framing_error out sticky bad-stop-bit flag
//   timeout       out sticky partial-message timeout (UART_RX_TIMEOUT_EN only)
module uart_receiving_msg
    import uart_pkg::*;
#(
    parameter int clk_freq      = 1000000,
    parameter int baud_rate     = 9600,
    parameter int msg_size_byte = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx,
    input  logic                       ack,
    output logic [8*msg_size_byte-1:0] msg,
    output logic                       msg_done,
    output logic [8:0]                 byte_count,
    output logic                       framing_error
`ifdef UART_RX_TIMEOUT_EN
   ,output logic                       timeout
`endif
);

    localparam int MW = 8 * msg_size_byte;

    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr;
    logic [MW-1:0] msg_q, msg_d;
    logic [8:0]    count_q, count_d;
    logic          done_q, done_d;
    logic          fe_q, fe_d;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * bit_ticks(clk_freq, baud_rate);
    localparam int TW       = $clog2(TO_LIMIT + 1);

    logic          rx_idle;
    logic [TW-1:0] idle_q, idle_d;
    logic          to_q, to_d;
`endif

    uart_rx_byte #(
        .CLK_FREQ  (clk_freq),
        .BAUD_RATE (baud_rate)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
`ifdef UART_RX_TIMEOUT_EN
       ,.idle       (rx_idle)
`endif
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            msg_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
            idle_q  <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            msg_q   <= msg_d;
            count_q <= count_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
`ifdef UART_RX_TIMEOUT_EN
            idle_q  <= idle_d;
            to_q    <= to_d;
`endif
        end
    end

    // Ordering: ack clears first, so a byte landing in the ack cycle becomes
    // byte 0 of the next message.
    always_comb begin
        msg_d   = msg_q;
        count_d = count_q;
        done_d  = done_q;
        fe_d    = fe_q;
`ifdef UART_RX_TIMEOUT_EN
        idle_d  = '0;
        to_d    = to_q;
`endif
        if (ack) begin
            msg_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
            fe_d    = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
            to_d    = 1'b0;
`endif
        end
`ifdef UART_RX_TIMEOUT_EN
        // Counts only with a partial message and the receiver idle
        else if (rx_idle && count_q != 9'd0 && !done_q) begin
            if (idle_q == TW'(TO_LIMIT - 1)) begin
                msg_d   = '0;
                count_d = '0;
                to_d    = 1'b1;
            end else begin
                idle_d  = idle_q + 1'b1;
            end
        end
`endif
        if (rx_ferr) fe_d = 1'b1;
        if (rx_valid && !done_d) begin
            for (int i = 0; i < msg_size_byte; i++) begin
                if (count_d == 9'(i)) msg_d[8*i +: 8] = rx_data;
            end
            count_d = count_d + 9'd1;
            if (count_d == 9'(msg_size_byte)) done_d = 1'b1;
        end
    end

    assign msg           = msg_q;
    assign msg_done      = done_q;
    assign byte_count    = count_q;
    assign framing_error = fe_q;
`ifdef UART_RX_TIMEOUT_EN
    assign timeout       = to_q;
`endif

endmodule
